// File: rtl/data_mem_resp.sv
// Single-port data RAM answering core load/store requests with a one-cycle
// registered response, range checking, access counters and a read/write protocol monitor.
`timescale 1ns/1ps

module data_mem_resp #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_req_i,
  input  logic        mem_wr_en_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_rvalid_o,
  output logic        mem_err_o,
  output logic        proto_err_o,
  output logic [15:0] rd_cnt_o,
  output logic [15:0] wr_cnt_o,
  output logic        fsm_state_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) << 2;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_HELD = 1'b1
  } state_e;

  // Handshake: mem_req_i is accepted on every rising edge (there is no ready);
  // each accepted request yields exactly one mem_rvalid_o pulse on the next cycle.

  logic [31:0]      ram [DEPTH_WORDS];
  logic [31:0]      offset;
  logic             in_range;
  logic [IDX_W-1:0] word_idx;
  logic [1:0]       unused_offset_lsb;
  logic             wr_fire;

  assign offset            = mem_addr_i - BASE_ADDR;
  assign in_range          = (mem_addr_i >= BASE_ADDR) && ({1'b0, offset} < SPAN);
  assign word_idx          = offset[IDX_W+1:2];
  assign unused_offset_lsb = offset[1:0];
  assign wr_fire           = mem_req_i && mem_wr_en_i && in_range;

  // RAM storage carries no reset so it can map onto block memory.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      ram[word_idx] <= mem_wdata_i;
    end
  end

  logic [31:0] rdata_d,  rdata_q;
  logic        rvalid_d, rvalid_q;
  logic        err_d,    err_q;
  logic [15:0] rd_cnt_d, rd_cnt_q;
  logic [15:0] wr_cnt_d, wr_cnt_q;

  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    err_d    = 1'b0;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (mem_req_i) begin
      rvalid_d = 1'b1;
      if (!in_range) begin
        rdata_d = 32'h0;
        err_d   = 1'b1;
      end else if (mem_wr_en_i) begin
        // Write-first: the response echoes the data being stored.
        rdata_d  = mem_wdata_i;
        wr_cnt_d = wr_cnt_q + 16'd1;
      end else begin
        rdata_d  = ram[word_idx];
        rd_cnt_d = rd_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q  <= 32'h0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rd_cnt_q <= 16'h0;
      wr_cnt_q <= 16'h0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  state_e      state_q;
  logic [29:0] held_word_q;
  logic        proto_err_q;

  // Protocol monitor: a write directly after a read must target the held word.
  // It only observes traffic and never gates the RAM path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      held_word_q <= 30'h0;
      proto_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_req_i && !mem_wr_en_i) begin
            state_q     <= RD_HELD;
            held_word_q <= mem_addr_i[31:2];
          end
        end
        RD_HELD: begin
          if (!mem_req_i) begin
            state_q <= IDLE;
          end else if (mem_wr_en_i) begin
            state_q <= IDLE;
            if (mem_addr_i[31:2] != held_word_q) begin
              proto_err_q <= 1'b1;
            end
          end else begin
            held_word_q <= mem_addr_i[31:2];
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_rdata_o  = rdata_q;
  assign mem_rvalid_o = rvalid_q;
  assign mem_err_o    = err_q;
  assign proto_err_o  = proto_err_q;
  assign rd_cnt_o     = rd_cnt_q;
  assign wr_cnt_o     = wr_cnt_q;
  assign fsm_state_o  = (state_q == RD_HELD);

endmodule

// File: tb/tb_data_mem_resp.sv
// Bench for data_mem_resp: directed scenarios plus randomized traffic checked
// against an array-based reference model of the memory and its protocol rules.
`timescale 1ns/1ps

module tb_data_mem_resp;

  localparam int unsigned DEPTH = 4096;
  localparam logic [31:0] BASE  = 32'h1000_0000;

  logic        clk;
  logic        rst_n;
  logic        mem_req_i;
  logic        mem_wr_en_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [31:0] mem_rdata_o;
  logic        mem_rvalid_o;
  logic        mem_err_o;
  logic        proto_err_o;
  logic [15:0] rd_cnt_o;
  logic [15:0] wr_cnt_o;
  logic        fsm_state_o;

  data_mem_resp #(
    .DEPTH_WORDS(DEPTH),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_req_i   (mem_req_i),
    .mem_wr_en_i (mem_wr_en_i),
    .mem_addr_i  (mem_addr_i),
    .mem_wdata_i (mem_wdata_i),
    .mem_rdata_o (mem_rdata_o),
    .mem_rvalid_o(mem_rvalid_o),
    .mem_err_o   (mem_err_o),
    .proto_err_o (proto_err_o),
    .rd_cnt_o    (rd_cnt_o),
    .wr_cnt_o    (wr_cnt_o),
    .fsm_state_o (fsm_state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [int];
  logic [31:0] m_rdata;
  logic        m_rvalid;
  logic        m_err;
  logic        m_proto;
  logic        m_prev_rd;
  logic [29:0] m_prev_word;
  logic [15:0] m_rd_cnt;
  logic [15:0] m_wr_cnt;
  logic [31:0] exp_q[$];

  function automatic bit addr_in_range(input logic [31:0] a);
    longint la;
    la = longint'(a);
    return (la >= longint'(BASE)) && (la < longint'(BASE) + 4 * longint'(DEPTH));
  endfunction

  task automatic model_reset();
    m_rdata   = 32'h0;
    m_rvalid  = 1'b0;
    m_err     = 1'b0;
    m_proto   = 1'b0;
    m_prev_rd = 1'b0;
    m_prev_word = 30'h0;
    m_rd_cnt  = 16'h0;
    m_wr_cnt  = 16'h0;
    exp_q.delete();
  endtask

  task automatic model_access(input logic req, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata);
    int idx;
    m_rvalid = req;
    m_err    = 1'b0;
    if (req) begin
      if (!addr_in_range(addr)) begin
        m_rdata = 32'h0;
        m_err   = 1'b1;
      end else begin
        idx = int'((addr - BASE) / 4);
        if (wr) begin
          ref_mem[idx] = wdata;
          m_rdata      = wdata;
          m_wr_cnt     = m_wr_cnt + 16'd1;
        end else begin
          m_rdata  = ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
          m_rd_cnt = m_rd_cnt + 16'd1;
        end
      end
      // A write right after a read must hit the word that was just read.
      if (wr && m_prev_rd && (addr[31:2] != m_prev_word)) m_proto = 1'b1;
    end
    m_prev_rd   = req && !wr;
    m_prev_word = addr[31:2];
    exp_q.push_back(m_rdata);
  endtask

  task automatic compare_all(input string tag);
    logic [31:0] exp_rdata;
    exp_rdata = exp_q.pop_front();
    check({tag, "/rdata"},  mem_rdata_o,         exp_rdata);
    check({tag, "/rvalid"}, 32'(mem_rvalid_o),   32'(m_rvalid));
    check({tag, "/err"},    32'(mem_err_o),      32'(m_err));
    check({tag, "/proto"},  32'(proto_err_o),    32'(m_proto));
    check({tag, "/rd_cnt"}, 32'(rd_cnt_o),       32'(m_rd_cnt));
    check({tag, "/wr_cnt"}, 32'(wr_cnt_o),       32'(m_wr_cnt));
    check({tag, "/state"},  32'(fsm_state_o),    32'(m_prev_rd));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input string tag, input logic req, input logic wr,
                      input logic [31:0] addr, input logic [31:0] wdata, input bit chk);
    @(negedge clk);
    mem_req_i   = req;
    mem_wr_en_i = wr;
    mem_addr_i  = addr;
    mem_wdata_i = wdata;
    model_access(req, wr, addr, wdata);
    @(posedge clk);
    #1;
    if (chk) compare_all(tag);
    else void'(exp_q.pop_front());
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "/rdata"},  mem_rdata_o,       32'h0);
    check({tag, "/rvalid"}, 32'(mem_rvalid_o), 32'h0);
    check({tag, "/err"},    32'(mem_err_o),    32'h0);
    check({tag, "/proto"},  32'(proto_err_o),  32'h0);
    check({tag, "/rd_cnt"}, 32'(rd_cnt_o),     32'h0);
    check({tag, "/wr_cnt"}, 32'(wr_cnt_o),     32'h0);
    check({tag, "/state"},  32'(fsm_state_o),  32'h0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n       = 1'b0;
    mem_req_i   = 1'b0;
    mem_wr_en_i = 1'b0;
    mem_addr_i  = 32'h0;
    mem_wdata_i = 32'h0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a;
    logic [31:0] d;
    logic [15:0] rd_before;
    logic [15:0] wr_before;
    int          kind;

    rst_n       = 1'b0;
    mem_req_i   = 1'b0;
    mem_wr_en_i = 1'b0;
    mem_addr_i  = 32'h0;
    mem_wdata_i = 32'h0;
    model_reset();
    apply_reset();

    // Write then read with ignored byte-offset bits.
    step("wr_dead", 1, 1, 32'h1000_0008, 32'hDEAD_BEEF, 1);
    step("rd_dead", 1, 0, 32'h1000_000B, 32'h0, 1);
    check("rd_dead/lit_rdata", mem_rdata_o, 32'hDEAD_BEEF);
    check("rd_dead/lit_rvalid", 32'(mem_rvalid_o), 32'd1);
    check("rd_dead/lit_cnts", {rd_cnt_o, wr_cnt_o}, {16'd1, 16'd1});
    step("idle_hold", 0, 0, 32'h0, 32'h0, 1);
    check("idle_hold/lit_rdata", mem_rdata_o, 32'hDEAD_BEEF);

    // Legal read-modify-write.
    step("rmw_pre", 1, 1, 32'h1000_0010, 32'h1122_3344, 1);
    step("rmw_gap", 0, 0, 32'h0, 32'h0, 1);
    step("rmw_rd",  1, 0, 32'h1000_0010, 32'h0, 1);
    check("rmw_rd/lit_rdata", mem_rdata_o, 32'h1122_3344);
    step("rmw_wr",  1, 1, 32'h1000_0010, 32'h11AA_3344, 1);
    check("rmw_wr/lit_proto", 32'(proto_err_o), 32'd0);
    check("rmw_wr/lit_state", 32'(fsm_state_o), 32'd0);
    step("rmw_chk", 1, 0, 32'h1000_0010, 32'h0, 1);
    check("rmw_chk/lit_rdata", mem_rdata_o, 32'h11AA_3344);

    // Protocol violation, then sticky through legal traffic.
    step("viol_rd", 1, 0, 32'h1000_0010, 32'h0, 1);
    step("viol_wr", 1, 1, 32'h1000_0014, 32'h5555_AAAA, 1);
    check("viol_wr/lit_proto", 32'(proto_err_o), 32'd1);
    step("sticky_a", 1, 1, 32'h1000_0020, 32'h0000_0001, 1);
    step("sticky_b", 0, 0, 32'h0, 32'h0, 1);
    step("sticky_c", 1, 0, 32'h1000_0020, 32'h0, 1);
    check("sticky_c/lit_proto", 32'(proto_err_o), 32'd1);

    // Out-of-range accesses on both boundaries.
    step("w0_init",  1, 1, BASE, 32'hA5A5_0000, 1);
    step("wlast",    1, 1, BASE + 4 * DEPTH - 4, 32'h7777_8888, 1);
    rd_before = rd_cnt_o;
    wr_before = wr_cnt_o;
    step("oor_wr",   1, 1, 32'h0FFF_FFFC, 32'hBAD0_BAD0, 1);
    check("oor_wr/lit_err", {31'h0, mem_err_o}, 32'd1);
    check("oor_wr/lit_rdata", mem_rdata_o, 32'h0);
    step("oor_rd",   1, 0, BASE + 4 * DEPTH, 32'h0, 1);
    check("oor_rd/lit_err", {31'h0, mem_err_o}, 32'd1);
    check("oor_cnts", {rd_cnt_o, wr_cnt_o}, {rd_before, wr_before});
    step("oor_after", 0, 0, 32'h0, 32'h0, 1);
    check("oor_after/lit_err", {31'h0, mem_err_o}, 32'd0);
    step("w0_keep",  1, 0, BASE, 32'h0, 1);
    check("w0_keep/lit_rdata", mem_rdata_o, 32'hA5A5_0000);
    step("wlast_rd", 1, 0, BASE + 4 * DEPTH - 1, 32'h0, 1);
    check("wlast_rd/lit_rdata", mem_rdata_o, 32'h7777_8888);

    // Reset asserted in the middle of a read request.
    step("pre_rst", 1, 0, 32'h1000_0008, 32'h0, 1);
    @(negedge clk);
    mem_req_i   = 1'b1;
    mem_wr_en_i = 1'b0;
    mem_addr_i  = 32'h1000_0008;
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_rst");
    @(posedge clk);
    #1;
    check_all_zero("mid_rst_edge");
    @(negedge clk);
    mem_req_i = 1'b0;
    rst_n     = 1'b1;
    model_reset();
    step("post_rst", 0, 0, 32'h0, 32'h0, 1);
    step("ram_kept", 1, 0, 32'h1000_0008, 32'h0, 1);
    check("ram_kept/lit_rdata", mem_rdata_o, 32'hDEAD_BEEF);

    // Randomized traffic over a preloaded window plus out-of-range addresses.
    for (int i = 0; i < 16; i++) step("preload", 1, 1, BASE + 4 * i, $urandom, 1);
    for (int i = 1; i <= 4; i++) step("preload_hi", 1, 1, BASE + 4 * DEPTH - 4 * i, $urandom, 1);
    for (int i = 0; i < 400; i++) begin
      kind = int'($urandom_range(0, 9));
      if (kind < 6)       a = BASE + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
      else if (kind < 7)  a = BASE + 4 * DEPTH - 4 * $urandom_range(1, 4) + $urandom_range(0, 3);
      else if (kind < 8)  a = BASE - 4 * $urandom_range(1, 1000) + $urandom_range(0, 3);
      else                a = BASE + 4 * DEPTH + 4 * $urandom_range(0, 1000) + $urandom_range(0, 3);
      d = $urandom;
      step("rand", ($urandom_range(0, 4) != 0), $urandom_range(0, 1) == 1, a, d, 1);
    end

    // Read counter wrap.
    apply_reset();
    step("wrap_init", 1, 1, BASE, 32'h0BAD_F00D, 1);
    for (int i = 0; i < 65535; i++) step("wrap", 1, 0, BASE, 32'h0, 0);
    check("wrap/ffff", 32'(rd_cnt_o), 32'h0000_FFFF);
    step("wrap_last", 1, 0, BASE, 32'h0, 1);
    check("wrap_last/lit_zero", 32'(rd_cnt_o), 32'h0);
    check("wrap_last/lit_rdata", mem_rdata_o, 32'h0BAD_F00D);
    step("wrap_idle", 0, 0, 32'h0, 32'h0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 4096, meaning the number of 32-bit RAM words (power of two).
REQ-002 The block SHALL have parameter BASE_ADDR, default 32'h1000_0000, meaning the byte address of word 0.
REQ-003 The block SHALL have port clk, input, 1 bit, the clock.
REQ-004 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port mem_req_i, input, 1 bit, access request from the core.
REQ-006 The block SHALL have port mem_wr_en_i, input, 1 bit: 1 = write, 0 = read.
REQ-007 The block SHALL have port mem_addr_i, input, 32 bits, byte address.
REQ-008 The block SHALL have port mem_wdata_i, input, 32 bits, full-word write data, already lane-merged by the core.
REQ-009 The block SHALL have port mem_rdata_o, output, 32 bits, registered read data.
REQ-010 The block SHALL have port mem_rvalid_o, output, 1 bit, one-cycle pulse marking mem_rdata_o as updated.
REQ-011 The block SHALL have port mem_err_o, output, 1 bit, one-cycle pulse for an out-of-range access.
REQ-012 The block SHALL have port proto_err_o, output, 1 bit, sticky protocol-violation flag.
REQ-013 The block SHALL have port rd_cnt_o, output, 16 bits, count of accepted reads.
REQ-014 The block SHALL have port wr_cnt_o, output, 16 bits, count of accepted writes.

Function
REQ-015 An access SHALL be in range when BASE_ADDR <= mem_addr_i < BASE_ADDR + 4*DEPTH_WORDS; the word index SHALL be (mem_addr_i - BASE_ADDR) >> 2.
REQ-016 mem_addr_i[1:0] SHALL be ignored; every access SHALL be full-word.
REQ-017 Read: on a rising edge with mem_req_i=1, mem_wr_en_i=0 and address in range, the next cycle SHALL present mem_rdata_o = RAM[index] and mem_rvalid_o = 1 (latency 1).
REQ-018 Write: on a rising edge with mem_req_i=1, mem_wr_en_i=1 and address in range, RAM[index] SHALL be updated to mem_wdata_i, and the next cycle SHALL present mem_rdata_o = mem_wdata_i (write-first) and mem_rvalid_o = 1.
REQ-019 Out of range: writes SHALL be dropped; the next cycle SHALL present mem_rdata_o = 0, mem_rvalid_o = 1 and mem_err_o = 1; the counters SHALL NOT increment.
REQ-020 When mem_req_i=0, mem_rdata_o SHALL hold its value, and mem_rvalid_o and mem_err_o SHALL be 0 the next cycle.
REQ-021 rd_cnt_o and wr_cnt_o SHALL increment by 1 per accepted in-range access and SHALL wrap from 16'hFFFF to 0.
REQ-022 The protocol FSM SHALL have states IDLE and RD_HELD, and SHALL register the read address in RD_HELD.
REQ-023 IDLE SHALL go to RD_HELD on a request with mem_wr_en_i=0 and SHALL stay in IDLE on a write or when there is no request.
REQ-024 From RD_HELD:
  - a write to the held word address -> IDLE (legal read-modify-write);
  - a write to any other address -> IDLE and set proto_err_o;
  - a read -> stay in RD_HELD and update the held address (load or back-to-back read);
  - no request -> IDLE.
REQ-025 proto_err_o SHALL be sticky until reset and SHALL NOT block or alter RAM accesses.
REQ-026 Back-to-back accesses to the same word SHALL be coherent: a read in the cycle after a write returns the written data.

Reset
REQ-027 On rst_n=0, asynchronously: mem_rdata_o = 0, mem_rvalid_o = 0, mem_err_o = 0, proto_err_o = 0, rd_cnt_o = 0, wr_cnt_o = 0, FSM = IDLE.
REQ-028 RAM contents SHALL NOT be reset.
REQ-029 A reset asserted mid-access SHALL discard the pending response; a write sampled on the same edge as reset assertion SHALL NOT be guaranteed.

Verification
REQ-030 Write then read: write 0xDEADBEEF to 0x1000_0008, then read 0x1000_000B -> rdata 0xDEADBEEF with rvalid=1 one cycle after the read; wr_cnt=1, rd_cnt=1.
REQ-031 Read-modify-write: read 0x1000_0010 (holding 0x11223344), next cycle write 0x11AA3344 to the same address -> proto_err=0, FSM=IDLE, and a subsequent read returns 0x11AA3344.
REQ-032 Protocol violation: read 0x1000_0010, next cycle write to 0x1000_0014 -> proto_err=1, and it stays 1 through further legal traffic until rst_n=0.
REQ-033 Out of range: write to 0x0FFF_FFFC and read from BASE_ADDR + 4*DEPTH_WORDS -> mem_err pulses one cycle each, rdata=0, counters unchanged, and RAM word 0 is not corrupted.
REQ-034 Counter wrap: 65536 in-range reads -> rd_cnt wraps to 0.
REQ-035 Reset mid-access: assert rst_n=0 during a read request -> all outputs are 0 immediately, and no rvalid follows release.
